// File: rtl/lk_regfile_ckpt_pkg.sv
// Shared defaults and checkpoint-control encoding for the
// checkpointed register file.
package lk_regfile_ckpt_pkg;

  localparam int WID_DEF   = 128;
  localparam int NREG_DEF  = 8;
  localparam int NCKPT_DEF = 4;

  typedef enum logic [1:0] {
    CK_IDLE    = 2'd0,
    CK_SAVE    = 2'd1,
    CK_RESTORE = 2'd2,
    CK_RELEASE = 2'd3
  } ckpt_op_e;

endpackage

// File: rtl/lk_ckpt_ctrl.sv
// Checkpoint stack bookkeeping: request priority, depth
// counter, full/empty and sticky error flags.
module lk_ckpt_ctrl
  import lk_regfile_ckpt_pkg::*;
#(
  parameter int NCKPT = NCKPT_DEF,
  parameter int CW    = $clog2(NCKPT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_save,
  input  logic          req_rest,
  input  logic          req_rel,
  output logic          push,
  output logic          pop,
  output logic          load,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  ckpt_op_e op;
  logic     ovf_set;
  logic     unf_set;

  assign full  = (cnt == CW'(NCKPT));
  assign empty = (cnt == '0);

  // Pick one request: restore beats release beats save.
  always_comb begin
    op = CK_IDLE;
    unique case (1'b1)
      req_rest:                          op = CK_RESTORE;
      (!req_rest && req_rel):            op = CK_RELEASE;
      (!req_rest && !req_rel && req_save): op = CK_SAVE;
      default:                           op = CK_IDLE;
    endcase
  end

  // Accept or reject the chosen request against stack state.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      CK_SAVE: begin
        if (full) ovf_set = 1'b1;
        else      push    = 1'b1;
      end
      CK_RESTORE: begin
        if (empty) unf_set = 1'b1;
        else begin
          pop  = 1'b1;
          load = 1'b1;
        end
      end
      CK_RELEASE: begin
        if (empty) unf_set = 1'b1;
        else       pop     = 1'b1;
      end
      default: ;
    endcase
  end

  // Depth counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push)     cnt <= cnt + CW'(1);
      else if (pop) cnt <= cnt - CW'(1);
      ovf <= ovf | ovf_set;
      unf <= unf | unf_set;
    end
  end

endmodule

// File: rtl/lk_regfile_ckpt.sv
// Dual-write, quad-read register file with a stack of
// full-file snapshots for save/restore/release.
module lk_regfile_ckpt
  import lk_regfile_ckpt_pkg::*;
#(
  parameter int WID   = WID_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NCKPT = NCKPT_DEF,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = $clog2(NCKPT) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr0,
  input  logic           wr1,
  input  logic [AW-1:0]  wa0,
  input  logic [AW-1:0]  wa1,
  input  logic [WID-1:0] i0,
  input  logic [WID-1:0] i1,
  input  logic [AW-1:0]  ra0,
  input  logic [AW-1:0]  ra1,
  input  logic [AW-1:0]  ra2,
  input  logic [AW-1:0]  ra3,
  output logic [WID-1:0] o0,
  output logic [WID-1:0] o1,
  output logic [WID-1:0] o2,
  output logic [WID-1:0] o3,
  input  logic           ckpt_save,
  input  logic           ckpt_restore,
  input  logic           ckpt_release,
  output logic [CW-1:0]  ckpt_cnt,
  output logic           ckpt_full,
  output logic           ckpt_empty,
  output logic           ovf,
  output logic           unf
);

  localparam int IW = (NCKPT > 1) ? $clog2(NCKPT) : 1;

  logic [WID-1:0] rf     [NREG];
  logic [WID-1:0] rf_nxt [NREG];
  logic [WID-1:0] snap   [NCKPT][NREG];
  logic [WID-1:0] rd     [4];
  logic [AW-1:0]  ra     [4];
  logic           push;
  logic           pop;
  logic           load;
  logic [CW-1:0]  cm1;
  logic [IW-1:0]  sp;
  logic [IW-1:0]  tp;

  lk_ckpt_ctrl #(
    .NCKPT (NCKPT),
    .CW    (CW)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .req_save (ckpt_save),
    .req_rest (ckpt_restore),
    .req_rel  (ckpt_release),
    .push     (push),
    .pop      (pop),
    .load     (load),
    .cnt      (ckpt_cnt),
    .full     (ckpt_full),
    .empty    (ckpt_empty),
    .ovf      (ovf),
    .unf      (unf)
  );

  assign cm1 = ckpt_cnt - CW'(1);
  assign sp  = IW'(ckpt_cnt);
  assign tp  = IW'(cm1);

  // Post-write file state; port 1 wins on an address clash.
  always_comb begin
    rf_nxt = rf;
    if (wr0 && wa0 != '0) rf_nxt[wa0] = i0;
    if (wr1 && wa1 != '0) rf_nxt[wa1] = i1;
  end

  // Live file: restore overrides this cycle's writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) rf[k] <= '0;
    end else if (load) begin
      rf <= snap[tp];
    end else begin
      rf <= rf_nxt;
    end
  end

  // Snapshot stack; contents only reachable below ckpt_cnt.
  always_ff @(posedge clk) begin
    if (push) snap[sp] <= rf_nxt;
  end

  assign ra[0] = ra0;
  assign ra[1] = ra1;
  assign ra[2] = ra2;
  assign ra[3] = ra3;

  // Read ports with write bypass, muted during a restore.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd[k] = rf[ra[k]];
      if (!load && wr0 && wa0 == ra[k]) rd[k] = i0;
      if (!load && wr1 && wa1 == ra[k]) rd[k] = i1;
      if (ra[k] == '0) rd[k] = '0;
    end
  end

  assign o0 = rd[0];
  assign o1 = rd[1];
  assign o2 = rd[2];
  assign o3 = rd[3];

endmodule

// File: tb/tb_lk_regfile_ckpt.sv
// Directed bench for lk_regfile_ckpt: bypass, snapshot
// stack, priority, sticky flags and async reset.
module tb_lk_regfile_ckpt;

  localparam int WID = 128;
  localparam int AW  = 3;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr0, wr1;
  logic [AW-1:0]  wa0, wa1;
  logic [WID-1:0] i0, i1;
  logic [AW-1:0]  ra0, ra1, ra2, ra3;
  logic [WID-1:0] o0, o1, o2, o3;
  logic           ckpt_save, ckpt_restore, ckpt_release;
  logic [CW-1:0]  ckpt_cnt;
  logic           ckpt_full, ckpt_empty, ovf, unf;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lk_regfile_ckpt dut (
    .clk          (clk),
    .rst          (rst),
    .wr0          (wr0),
    .wr1          (wr1),
    .wa0          (wa0),
    .wa1          (wa1),
    .i0           (i0),
    .i1           (i1),
    .ra0          (ra0),
    .ra1          (ra1),
    .ra2          (ra2),
    .ra3          (ra3),
    .o0           (o0),
    .o1           (o1),
    .o2           (o2),
    .o3           (o3),
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .ckpt_release (ckpt_release),
    .ckpt_cnt     (ckpt_cnt),
    .ckpt_full    (ckpt_full),
    .ckpt_empty   (ckpt_empty),
    .ovf          (ovf),
    .unf          (unf)
  );

  task automatic chk(input string tag,
                     input logic [WID-1:0] got,
                     input logic [WID-1:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wr0 = 0; wr1 = 0; wa0 = '0; wa1 = '0;
    i0 = '0; i1 = '0;
    ra0 = '0; ra1 = '0; ra2 = '0; ra3 = '0;
    ckpt_save = 0; ckpt_restore = 0; ckpt_release = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    #1;
    chk("rst_o0", o0, 0);
    chk("rst_cnt", ckpt_cnt, 0);
    chk("rst_empty", ckpt_empty, 1);
    chk("rst_full", ckpt_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    #2 rst = 0;
    cyc();

    // Dual write to r3: port 1 wins, bypass and store.
    wr0 = 1; wa0 = 3; i0 = 'hA5;
    wr1 = 1; wa1 = 3; i1 = 'h5A;
    ra0 = 3;
    #1 chk("byp_dual", o0, 'h5A);
    cyc(); clr(); ra0 = 3;
    #1 chk("st_dual", o0, 'h5A);

    // r0 discards writes; single-port bypass.
    wr0 = 1; wa0 = 0; i0 = 'hFF; ra1 = 0;
    wr1 = 1; wa1 = 6; i1 = 'h66; ra2 = 6;
    #1 chk("r0_byp", o1, 0);
    chk("byp_p1", o2, 'h66);
    cyc(); clr(); ra1 = 0; ra3 = 6;
    #1 chk("r0_st", o1, 0);
    chk("st_r6", o3, 'h66);

    // r2=11, save, r2=22, restore.
    wr0 = 1; wa0 = 2; i0 = 'h11; cyc(); clr();
    ckpt_save = 1; cyc(); clr();
    #1 chk("save_cnt", ckpt_cnt, 1);
    wr1 = 1; wa1 = 2; i1 = 'h22; cyc(); clr();
    ckpt_restore = 1; ra0 = 2;
    #1 chk("rest_cur", o0, 'h22);
    cyc(); clr(); ra0 = 2;
    #1 chk("rest_nxt", o0, 'h11);
    chk("rest_cnt", ckpt_cnt, 0);

    // Fill stack, overflow, then restore once.
    ckpt_save = 1;
    repeat (4) cyc();
    clr();
    #1 chk("fill_cnt", ckpt_cnt, 4);
    chk("fill_full", ckpt_full, 1);
    chk("fill_ovf", ovf, 0);
    ckpt_save = 1; cyc(); clr();
    #1 chk("ovf_cnt", ckpt_cnt, 4);
    chk("ovf_flag", ovf, 1);
    ckpt_restore = 1; cyc(); clr();
    #1 chk("ovf_rcnt", ckpt_cnt, 3);
    chk("ovf_rfull", ckpt_full, 0);
    chk("ovf_unf", unf, 0);

    // Drain, then release on empty with a write.
    ckpt_release = 1;
    repeat (3) cyc();
    clr();
    #1 chk("drain_empty", ckpt_empty, 1);
    chk("drain_unf", unf, 0);
    ckpt_release = 1; wr0 = 1; wa0 = 5; i0 = 'h7;
    cyc(); clr(); ra1 = 5;
    #1 chk("unf_flag", unf, 1);
    chk("unf_wr", o1, 'h7);
    chk("unf_cnt", ckpt_cnt, 0);
    chk("ovf_sticky", ovf, 1);

    // Fresh start: save+restore together at depth 2.
    rst = 1; #1 rst = 0;
    wr0 = 1; wa0 = 4; i0 = 'h44; ckpt_save = 1;
    cyc(); clr();
    wr1 = 1; wa1 = 4; i1 = 'h55; ckpt_save = 1;
    cyc(); clr();
    wr0 = 1; wa0 = 4; i0 = 'h77; cyc(); clr();
    #1 chk("pri_cnt2", ckpt_cnt, 2);
    ckpt_save = 1; ckpt_restore = 1;
    wr0 = 1; wa0 = 4; i0 = 'h99; ra0 = 4;
    #1 chk("pri_nobyp", o0, 'h77);
    cyc(); clr(); ra0 = 4;
    #1 chk("pri_r4", o0, 'h55);
    chk("pri_cnt", ckpt_cnt, 1);
    chk("pri_ovf", ovf, 0);
    chk("pri_unf", unf, 0);
    ckpt_restore = 1; cyc(); clr(); ra0 = 4;
    #1 chk("pri_r4b", o0, 'h44);
    chk("pri_cnt0", ckpt_cnt, 0);

    // Build state, then async reset mid-cycle.
    ckpt_release = 1; cyc(); clr();
    wr0 = 1; wa0 = 1; i0 = 'hDEAD; cyc(); clr();
    ckpt_save = 1;
    repeat (5) cyc();
    clr();
    #1 chk("pre_ovf", ovf, 1);
    chk("pre_unf", unf, 1);
    #2;
    ckpt_save = 1; ra0 = 1;
    rst = 1;
    #1 chk("arst_o0", o0, 0);
    chk("arst_cnt", ckpt_cnt, 0);
    chk("arst_empty", ckpt_empty, 1);
    chk("arst_ovf", ovf, 0);
    chk("arst_unf", unf, 0);
    cyc();
    chk("arst_hold", ckpt_cnt, 0);
    rst = 0; clr();
    ckpt_restore = 1; ra0 = 1;
    cyc(); clr(); ra0 = 1;
    #1 chk("post_o0", o0, 0);
    chk("post_cnt", ckpt_cnt, 0);
    chk("post_unf", unf, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/lk_regfile_ckpt.md
LK_REGFILE_CKPT -- requirements
Module: lk_regfile_ckpt

Interface
REQ-001 Parameter WID, default 128, register data width in bits.
REQ-002 Parameter NREG, default 8, register count; power of two, at least 4.
REQ-003 Parameter NCKPT, default 4, checkpoint stack depth, at least 1.
REQ-004 Port list, in order (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- wr0, wr1  in  1  write enables for write ports 0 and 1.
- wa0, wa1  in  log2(NREG)  write addresses.
- i0, i1  in  WID  write data.
- ra0, ra1, ra2, ra3  in  log2(NREG)  read addresses.
- o0, o1, o2, o3  out  WID  read data.
- ckpt_save  in  1  push a snapshot of the register file.
- ckpt_restore  in  1  pop the top snapshot into the live file.
- ckpt_release  in  1  pop and discard the top snapshot.
- ckpt_cnt  out  log2(NCKPT)+1  number of valid snapshots.
- ckpt_full, ckpt_empty  out  1  ckpt_cnt==NCKPT, ckpt_cnt==0.
- ovf, unf  out  1  sticky overflow and underflow flags.

Function
REQ-005 Register 0 SHALL always read zero; writes to address 0 SHALL be discarded.
REQ-006 Both write ports SHALL commit on the same clk edge; no double-rate clock is used.
REQ-007 When wr0 and wr1 are both high and wa0==wa1, port 1 data SHALL be written.
REQ-008 Reads SHALL be combinational: oN = 0 if raN==0; else i1 if wr1 and wa1==raN; else i0 if wr0 and wa0==raN; else the stored value.
REQ-009 Bypass SHALL be suppressed in any cycle where ckpt_restore is accepted, so reads return stored (pre-restore) values.
REQ-010 An accepted ckpt_save SHALL push the post-write state of that cycle, including same-cycle writes, and increment ckpt_cnt at the next edge.
REQ-011 An accepted ckpt_restore SHALL load the top snapshot into the live file at the next edge, discard all writes in that cycle, and decrement ckpt_cnt.
REQ-012 The restored value SHALL be visible on the outputs from the cycle following the restore.
REQ-013 An accepted ckpt_release SHALL decrement ckpt_cnt and leave the live file unchanged; writes proceed normally.
REQ-014 Priority among checkpoint requests in one cycle SHALL be restore > release > save; lower-priority requests SHALL be ignored without setting any flag.
REQ-015 ckpt_save while ckpt_full SHALL be ignored and SHALL set ovf.
REQ-016 ckpt_restore or ckpt_release while ckpt_empty SHALL be ignored and SHALL set unf; a write in that cycle SHALL still commit.
REQ-017 ovf and unf SHALL stay set until reset.
REQ-018 Snapshot storage SHALL be a stack indexed by ckpt_cnt; ckpt_cnt SHALL never wrap past 0 or NCKPT.
REQ-019 ckpt_full, ckpt_empty, ovf and unf SHALL be registered or derived only from registered state.

Reset
REQ-020 While rst is high: all live registers zero, ckpt_cnt=0, ckpt_empty=1, ckpt_full=0, ovf=0, unf=0.
REQ-021 Snapshot contents need not be cleared and SHALL be unobservable after reset.
REQ-022 Reset asserted mid-operation SHALL abort any pending save, restore or release in that cycle.

Structure
REQ-023 A shared package SHALL hold the default WID, NREG and NCKPT values and a typedef for the checkpoint-control encoding.
REQ-024 One sub-module, lk_ckpt_ctrl, SHALL own ckpt_cnt, request priority, the full/empty flags and the sticky flags, and SHALL emit push, pop and load strobes.

Verification
REQ-025 Write 0xA5 to r3 on wr0 and 0x5A to r3 on wr1 in the same cycle -> ra0=3 bypasses 0x5A in that cycle; the stored value reads 0x5A next cycle.
REQ-026 Write r2=0x11, then save, then write r2=0x22, then restore -> r2 reads 0x22 during the restore cycle and 0x11 in the following cycle; ckpt_cnt goes 1 then 0.
REQ-027 Perform NCKPT saves, then one more save -> ckpt_full=1, ckpt_cnt=NCKPT, ovf=1; a following restore gives ckpt_cnt=NCKPT-1 and ckpt_full=0.
REQ-028 Release on an empty stack together with a write r5=0x7 -> unf=1, r5 reads 0x7, ckpt_cnt stays 0.
REQ-029 Save and restore asserted together with ckpt_cnt=2 -> restore taken, ckpt_cnt=1, the write in that cycle is dropped, no flag set.
REQ-030 Assert rst asynchronously mid-cycle after several writes and saves -> all reads return 0 immediately, ckpt_cnt=0, ovf=0, unf=0.
